// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter fed by a transmit FIFO; parity bit enabled by UART_TX_PARITY_EN
module uart_tx_fifo #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          user_clock,
  input  logic                          rst,
  input  logic                          send_trigger,
  input  logic [DATA_BITS-1:0]          send_data,
  input  logic                          parity_odd,
  input  logic                          overflow_clr,
  output logic                          usb_rs232_txd,
  output logic                          busy,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          gpio_led1
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t state, state_nxt;

  logic                 trig_q;
  logic                 push, pop, accept;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic                 ovf_q;

  logic [CW-1:0]        baud_cnt;
  logic                 baud_done;
  logic [3:0]           bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 frame_done;
  logic                 txd_nxt;
  logic                 txd_q, busy_q, led_q;

`ifdef UART_TX_PARITY_EN
  logic                 par_q;
`else
  logic                 unused_parity;
  assign unused_parity = parity_odd;
`endif

  assign push       = send_trigger & ~trig_q;
  assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  // A pop in the same cycle frees a slot, so a push onto a full queue still lands.
  assign accept     = push & (~fifo_full | pop);
  assign baud_done  = (baud_cnt == BAUD_LAST);

  assign usb_rs232_txd = txd_q;
  assign busy          = busy_q;
  assign fifo_count    = count;
  assign overflow      = ovf_q;
  assign gpio_led1     = led_q;

  always_ff @(posedge user_clock or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    frame_done = 1'b0;
    txd_nxt    = 1'b1;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        txd_nxt = 1'b0;
        if (baud_done) state_nxt = DATA;
      end
      DATA: begin
        txd_nxt = shreg[0];
        if (baud_done && bit_idx == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        txd_nxt = par_q;
        if (baud_done) state_nxt = STOP;
      end
`endif
      STOP: begin
        txd_nxt = 1'b1;
        if (baud_done && stop_idx == STOP_LAST) begin
          frame_done = 1'b1;
          // Chain straight into the next start bit when more data is waiting.
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge user_clock or negedge rst) begin
    if (!rst) begin
      trig_q <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      trig_q <= send_trigger;
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      if (accept && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !accept) count <= count - (AW+1)'(1);
      if (push && !accept)   ovf_q <= 1'b1;
      else if (overflow_clr) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge user_clock) begin
    if (accept) mem[wr_ptr] <= send_data;
  end

  always_ff @(posedge user_clock or negedge rst) begin
    if (!rst) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      led_q    <= 1'b0;
    end else begin
      if (state == IDLE || baud_done) baud_cnt <= '0;
      else                            baud_cnt <= baud_cnt + CW'(1);

      if (state != DATA)  bit_idx <= '0;
      else if (baud_done) bit_idx <= bit_idx + 4'd1;

      if (state != STOP)  stop_idx <= 1'b0;
      else if (baud_done) stop_idx <= ~stop_idx;

      if (pop)                            shreg <= mem[rd_ptr];
      else if (state == DATA && baud_done) shreg <= shreg >> 1;

      // Line and busy are registered together so busy frames exactly the bits on txd.
      txd_q  <= txd_nxt;
      busy_q <= (state != IDLE);
      led_q  <= led_q ^ frame_done;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge user_clock or negedge rst) begin
    if (!rst)     par_q <= 1'b0;
    else if (pop) par_q <= (^mem[rd_ptr]) ^ parity_odd;
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - randomized scoreboard bench for uart_tx_fifo against a timing-level frame model
module tb_uart_tx_fifo;

  localparam int CLK_HZ     = 50000000;
  localparam int BAUD       = 2500000;
  localparam int DATA_BITS  = 8;
  localparam int STOP_BITS  = 1;
  localparam int FIFO_DEPTH = 16;
  localparam int DIV        = CLK_HZ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int NBITS = 1 + DATA_BITS + PAR_BITS + STOP_BITS;
  localparam int FRAME = NBITS * DIV;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 send_trigger;
  logic [DATA_BITS-1:0] send_data;
  logic                 parity_odd;
  logic                 overflow_clr;
  logic                 txd, busy, fifo_full, fifo_empty, overflow, gpio_led1;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  uart_tx_fifo #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(DATA_BITS),
    .STOP_BITS(STOP_BITS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .user_clock(clk), .rst(rst), .send_trigger(send_trigger), .send_data(send_data),
    .parity_odd(parity_odd), .overflow_clr(overflow_clr), .usb_rs232_txd(txd),
    .busy(busy), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_count(fifo_count), .overflow(overflow), .gpio_led1(gpio_led1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int push_e; int pop_e; } ent_t;
  typedef struct { logic [7:0] d; logic po; int start_e; } frm_t;

  ent_t ents[$];
  frm_t expq[$];
  int   next_free = 0;
  bit   ovf_m = 0;
  int   vectors = 0;
  int   miscompares = 0;

  bit   mon_busy = 0;
  int   fall_e = 0;
  frm_t cur;
  bit   frm_err = 0;
  int   bad_off = 0;
  int   frames_done = 0;

  function automatic int model_occ(input int c);
    int n = 0;
    foreach (ents[i]) if (ents[i].push_e <= c && ents[i].pop_e > c) n++;
    return n;
  endfunction

  function automatic logic frame_bit(input logic [7:0] d, input logic po, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= DATA_BITS) return d[idx-1];
    if (PAR_BITS == 1 && idx == DATA_BITS + 1) return (^d) ^ po;
    return 1'b1;
  endfunction

  // A byte accepted at edge k is popped when the line is free (never before k+1)
  // and its start bit appears one edge after the pop.
  task automatic push_byte(input logic [7:0] d, input int hold, input int gap, input int at_edge);
    int k, p;
    @(negedge clk);
    while (at_edge >= 0 && cyc < at_edge - 1) @(negedge clk);
    k = cyc + 1;
    send_trigger = 1'b1;
    send_data    = d;
    if (model_occ(k) < FIFO_DEPTH) begin
      p = (k + 1 > next_free) ? k + 1 : next_free;
      next_free = p + FRAME;
      ents.push_back('{k, p});
      expq.push_back('{d, parity_odd, p + 1});
    end else begin
      ovf_m = 1'b1;
    end
    for (int h = 1; h < hold; h++) begin
      @(negedge clk);
      send_data = 8'($urandom);
    end
    @(negedge clk);
    send_trigger = 1'b0;
    send_data    = 8'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  task automatic clear_ovf();
    @(negedge clk);
    overflow_clr = 1'b1;
    ovf_m        = 1'b0;
    @(negedge clk);
    overflow_clr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b0;
    send_trigger = 1'b0;
    overflow_clr = 1'b0;
    #1;
    vectors++;
    if (txd !== 1'b1 || busy !== 1'b0 || fifo_empty !== 1'b1 || fifo_full !== 1'b0 ||
        fifo_count !== '0 || overflow !== 1'b0 || gpio_led1 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: txd=%b busy=%b empty=%b full=%b count=%0d ovf=%b led=%b, want 1 0 1 0 0 0 0",
               txd, busy, fifo_empty, fifo_full, fifo_count, overflow, gpio_led1);
    end
    ents.delete();
    expq.delete();
    next_free = 0;
    ovf_m     = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((expq.size() != 0 || mon_busy || busy === 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n >= budget) begin
      miscompares++;
      $display("FAIL idle_timeout: %0d frames still pending after %0d cycles, want 0", expq.size(), n);
    end
    repeat (3) @(negedge clk);
  endtask

  always @(posedge clk) begin
    int  off, occ;
    bit  exp_busy;
    #1;
    if (rst !== 1'b1) begin
      mon_busy    = 1'b0;
      frames_done = 0;
    end else begin
      if (!mon_busy && txd === 1'b0) begin
        vectors++;
        if (expq.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_frame: start bit at edge %0d, want no frame", cyc);
        end else begin
          cur      = expq.pop_front();
          mon_busy = 1'b1;
          fall_e   = cyc;
          frm_err  = 1'b0;
          if (cyc != cur.start_e) begin
            miscompares++;
            $display("FAIL frame_start: byte %h started at edge %0d, want %0d", cur.d, cyc, cur.start_e);
          end
        end
      end
      exp_busy = mon_busy;
      if (mon_busy) begin
        off = cyc - fall_e;
        if (!frm_err && (txd !== frame_bit(cur.d, cur.po, off / DIV) || busy !== 1'b1)) begin
          frm_err = 1'b1;
          bad_off = off;
        end
        if (off == FRAME - 1) begin
          frames_done++;
          vectors++;
          if (frm_err) begin
            miscompares++;
            $display("FAIL frame_bits: byte %h wrong at cycle %0d of frame (bit %0d), got txd=%b busy=%b, want txd=%b busy=1",
                     cur.d, bad_off, bad_off / DIV, txd, busy, frame_bit(cur.d, cur.po, bad_off / DIV));
          end
          vectors++;
          if (gpio_led1 !== frames_done[0]) begin
            miscompares++;
            $display("FAIL led_toggle: got %b after %0d frames, want %b", gpio_led1, frames_done, frames_done[0]);
          end
          mon_busy = 1'b0;
        end
      end
      occ = model_occ(cyc);
      vectors++;
      if (fifo_count !== occ || fifo_full !== (occ == FIFO_DEPTH) || fifo_empty !== (occ == 0) ||
          overflow !== ovf_m || busy !== exp_busy) begin
        miscompares++;
        $display("FAIL status @%0d: count=%0d full=%b empty=%b ovf=%b busy=%b, want count=%0d full=%b empty=%b ovf=%b busy=%b",
                 cyc, fifo_count, fifo_full, fifo_empty, overflow, busy,
                 occ, occ == FIFO_DEPTH, occ == 0, ovf_m, exp_busy);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", vectors, miscompares);
    $fatal(1);
  end

  initial begin
    logic [31:0] alex;
    int n;
    rst          = 1'b0;
    send_trigger = 1'b0;
    send_data    = '0;
    parity_odd   = 1'b0;
    overflow_clr = 1'b0;
    do_reset();

    push_byte(8'h41, 40, 5, -1);
    wait_idle(FRAME * 3);

    alex = "ALEX";
    for (int i = 3; i >= 0; i--) push_byte(alex[i*8 +: 8], 2, 3, -1);
    wait_idle(FRAME * 6);

    for (int i = 0; i < 18; i++) push_byte(8'($urandom), 1, 1, -1);
    push_byte(8'h99, 1, 1, ents[1].pop_e);
    clear_ovf();
    wait_idle(FRAME * 25);

    parity_odd = 1'($urandom);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) < 7)
        push_byte(8'($urandom), $urandom_range(1, 6), $urandom_range(0, 10), -1);
      else
        push_byte(8'($urandom), $urandom_range(1, 6), $urandom_range(FRAME / 2, 2 * FRAME), -1);
      if ($urandom_range(0, 9) == 0) clear_ovf();
    end
    wait_idle(FRAME * 25);

    parity_odd = ~parity_odd;
    for (int i = 0; i < 4; i++) push_byte(8'($urandom), 1, 2, -1);
    n = 0;
    while (!(mon_busy && cyc - fall_e == 4 * DIV + DIV / 2) && n < FRAME * 2) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n >= FRAME * 2) begin
      miscompares++;
      $display("FAIL data_bit3_wait: never reached data bit 3 in %0d cycles", n);
    end
    do_reset();
    repeat (FRAME * 4) @(negedge clk);
    push_byte(8'h5A, 3, 2, -1);
    wait_idle(FRAME * 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, user_clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, line rate; bit period DIV = CLK_HZ/BAUD cycles, truncated (434 at defaults).
REQ-003 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal 5..9.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits per frame, legal 1 or 2.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16, transmit queue entries, power of two, 2..256.
REQ-006 SHALL have port user_clock, input, 1, single clock; all logic rising-edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port send_trigger, input, 1, push request; a push occurs on its rising edge only.
REQ-009 SHALL have port send_data, input, DATA_BITS, byte captured on the push edge.
REQ-010 SHALL have port parity_odd, input, 1, 1 selects odd parity and 0 selects even; used only per REQ-031.
REQ-011 SHALL have port overflow_clr, input, 1, synchronous clear of overflow.
REQ-012 SHALL have port usb_rs232_txd, output, 1, serial line, idle high.
REQ-013 SHALL have port busy, output, 1, high while a frame is on the line.
REQ-014 SHALL have ports fifo_full and fifo_empty, output, 1 each, queue status.
REQ-015 SHALL have port fifo_count, output, clog2(FIFO_DEPTH)+1, queued entries.
REQ-016 SHALL have port overflow, output, 1, sticky dropped-push flag.
REQ-017 SHALL have port gpio_led1, output, 1, toggles once per completed frame.

Function
REQ-018 SHALL register send_trigger and detect push = high now AND low on previous edge; a held level SHALL push exactly once.
REQ-019 SHALL write send_data into the FIFO on the detection edge k when not full.
REQ-020 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
REQ-021 In IDLE with FIFO non-empty, SHALL pop at the next edge and enter START; for an idle push at edge k, txd SHALL go low from edge k+2.
REQ-022 SHALL hold each bit exactly DIV cycles, measured by a baud counter reloaded at every bit boundary.
REQ-023 SHALL send start 0, data LSB first, optional parity, then STOP_BITS high bits.
REQ-024 At the end of STOP with FIFO non-empty, SHALL go directly to START with zero idle cycles; otherwise SHALL return to IDLE.
REQ-025 busy SHALL be high from the first START cycle to the last STOP cycle inclusive.
REQ-026 A push while full SHALL be dropped and set overflow; a pop in the same cycle SHALL free the slot first, so that push is accepted.
REQ-027 overflow SHALL clear on overflow_clr high; a simultaneous overflow event SHALL win.
REQ-028 Read/write pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL range 0..FIFO_DEPTH.

Reset
REQ-029 rst low SHALL immediately force txd=1, busy=0, fifo_empty=1, fifo_full=0, fifo_count=0, overflow=0, gpio_led1=0, FSM=IDLE, counters=0.
REQ-030 Reset mid-frame SHALL abort the frame and discard queued data; after release, transmission SHALL resume only on new pushes.

Configuration
REQ-031 Macro UART_TX_PARITY_EN defined: SHALL insert a PARITY bit after data equal to XOR of the data bits, XORed with parity_odd. Undefined: SHALL omit the PARITY state and ignore parity_odd, and the frame SHALL be 1+DATA_BITS+STOP_BITS bits.

Verification (defaults, 50 MHz, DIV=434)
REQ-032 Reset: rst low mid-operation -> txd=1, busy=0, fifo_empty=1, fifo_count=0, gpio_led1=0 in the same cycle.
REQ-033 Single byte: 0x41 ('A') with a 40-cycle trigger pulse -> one frame on txd, bits 0,1,0,0,0,0,0,1,0,1, each 434 cycles; gpio_led1 toggles once.
REQ-034 Burst: "ALEX" pushed within 200 cycles -> four back-to-back frames, 17360 cycles total with no idle gap; busy stays high throughout.
REQ-035 Overflow: 18 pushes within 400 cycles -> fifo_full=1, overflow=1, 17 frames sent, 18th byte never transmitted; overflow_clr clears the flag.
REQ-036 Parity (macro defined): 0x41 with parity_odd=0 -> parity bit 0; with parity_odd=1 -> parity bit 1; frame is 11 bits (4774 cycles).
REQ-037 Mid-frame reset: rst low during data bit 3 with 3 entries queued -> txd=1 at once and no further frames after release.
